// File: rtl/cdb_pkg.sv
// Shared common-data-bus definitions: default widths, the reserved "no tag"
// queue id, and the broadcast message layout seen by reservation stations
// and the register-status table.
package cdb_pkg;

    localparam int ID_W   = 3;
    localparam int DATA_W = 32;

    // Queue id 0 means "no tag / register ready"; it must never be broadcast.
    localparam int unsigned CDB_ID_NONE = 0;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic              int_flag;
        logic [DATA_W-1:0] data;
    } cdb_msg_t;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotating priority encoder: starting at ptr and wrapping modulo N_REQ,
// picks the first asserted request. Purely combinational.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    int unsigned      cand;
    logic [PTR_W-1:0] cand_idx;

    // Walk ptr, ptr+1, ... (mod N_REQ); first requester found wins.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < int'(N_REQ); k++) begin
            cand = int'(ptr) + k;
            if (cand >= int'(N_REQ)) begin
                cand = cand - int'(N_REQ);
            end
            cand_idx = PTR_W'(cand);
            if (!any && req[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus. One requester is granted per
// cycle; its result is registered and broadcast for exactly one cycle.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = cdb_pkg::DATA_W,
    parameter int ID_W   = cdb_pkg::ID_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ID_W-1:0]   req_id,
    input  logic [N_REQ-1:0]        req_int,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_grant,
    input  logic                    hold,
    input  logic                    flush,
    output logic                    cdb_valid,
    output logic [ID_W-1:0]         cdb_id,
    output logic                    cdb_int,
    output logic [DATA_W-1:0]       cdb_data,
    output logic                    id_err
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic [N_REQ-1:0]  pick_grant;
    logic [PTR_W-1:0]  pick_idx;
    logic              pick_any;
    logic              grant_en;
    logic              fire;
    logic [ID_W-1:0]   sel_id;
    logic              sel_int;
    logic [DATA_W-1:0] sel_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Gate grants with hold/flush and select the winner's payload.
    always_comb begin
        grant_en  = !hold && !flush;
        fire      = grant_en && pick_any;
        req_grant = grant_en ? pick_grant : '0;
        sel_id    = req_id[int'(pick_idx)*ID_W +: ID_W];
        sel_int   = req_int[pick_idx];
        sel_data  = req_data[int'(pick_idx)*DATA_W +: DATA_W];
        if (int'(pick_idx) == N_REQ - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = pick_idx + PTR_W'(1);
        end
    end

    // Broadcast register, priority pointer and sticky id-0 error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_id    <= '0;
            cdb_int   <= 1'b0;
            cdb_data  <= '0;
            id_err    <= 1'b0;
        end else if (flush) begin
            ptr       <= '0;
            cdb_valid <= 1'b0;
            cdb_id    <= '0;
            cdb_int   <= 1'b0;
            cdb_data  <= '0;
        end else if (fire) begin
            ptr       <= ptr_nxt;
            cdb_valid <= 1'b1;
            cdb_id    <= sel_id;
            cdb_int   <= sel_int;
            cdb_data  <= sel_data;
            if (sel_id == ID_W'(CDB_ID_NONE)) begin
                id_err <= 1'b1;
            end
        end else begin
            cdb_valid <= 1'b0;
            cdb_id    <= '0;
            cdb_int   <= 1'b0;
            cdb_data  <= '0;
        end
    end

endmodule
